// File: rtl/mux_scan_sampler_if.sv
// Handshake and mux-control bundle between a scan sampler and its requester.
// The sampler drives the 4:1 select lines and reads back the mux output on f.
interface mux_scan_sampler_if;
  logic       start;
  logic [3:0] mask;
  logic       f;
  logic       s0;
  logic       s1;
  logic       busy;
  logic [3:0] frame;
  logic       frame_valid;
  logic       frame_ready;

  modport master (output start, mask, f, frame_ready,
                  input  s0, s1, busy, frame, frame_valid);
  modport slave  (input  start, mask, f, frame_ready,
                  output s0, s1, busy, frame, frame_valid);
endinterface

// File: rtl/mux_scan_sampler.sv
// Steps a 4:1 mux across the enabled channels, waits SETTLE cycles on each,
// then samples f into one bit of a frame that is held until the consumer takes it.
module mux_scan_sampler #(
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  mux_scan_sampler_if.slave bus
);
  localparam logic [3:0] SETTLE_C  = SETTLE[3:0];
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_VALID  = 2'd2;

  logic [1:0] state;
  logic [1:0] ch;
  logic [3:0] cnt;
  logic [3:0] mask_q;
  logic [3:0] frame_q;
  logic [3:0] higher;
  logic       accept;

  function automatic logic [1:0] low_bit(input logic [3:0] m);
    casez (m)
      4'b???1: return 2'd0;
      4'b??10: return 2'd1;
      4'b?100: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // enabled channels strictly above the current one
  assign higher = mask_q & (4'b1110 << ch);
  assign accept = bus.start &&
                  (state == ST_IDLE || (state == ST_VALID && bus.frame_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ch      <= 2'd0;
      cnt     <= 4'd0;
      mask_q  <= 4'd0;
      frame_q <= 4'd0;
    end else begin
      case (state)
        ST_IDLE, ST_VALID: begin
          if (accept) begin
            frame_q <= 4'd0;
            if (|bus.mask) begin
              mask_q <= bus.mask;
              ch     <= low_bit(bus.mask);
              cnt    <= 4'd0;
              state  <= ST_SETTLE;
            end else begin
              state  <= ST_VALID;
            end
          end else if (state == ST_VALID && bus.frame_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (cnt != SETTLE_C) begin
            cnt <= cnt + 4'd1;
          end else begin
            frame_q[ch] <= bus.f;
            cnt         <= 4'd0;
            if (|higher) ch <= low_bit(higher);
            else         state <= ST_VALID;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // selects park at channel 0 outside a scan
  assign bus.s0          = (state == ST_SETTLE) & ch[0];
  assign bus.s1          = (state == ST_SETTLE) & ch[1];
  assign bus.busy        = (state == ST_SETTLE);
  assign bus.frame_valid = (state == ST_VALID);
  assign bus.frame       = frame_q;
endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench for mux_scan_sampler: one instance with SETTLE=2, one with SETTLE=0,
// sharing stimulus; f is modelled as the selected bit of a per-test channel value vector.
module tb_mux_scan_sampler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start, frame_ready, f_ovr_en, f_ovr, use0;
  logic [3:0] mask, vals;

  mux_scan_sampler_if b2();
  mux_scan_sampler_if b0();

  assign b2.start = start;  assign b2.mask = mask;  assign b2.frame_ready = frame_ready;
  assign b0.start = start;  assign b0.mask = mask;  assign b0.frame_ready = frame_ready;
  assign b2.f = f_ovr_en ? f_ovr : vals[{b2.s1, b2.s0}];
  assign b0.f = f_ovr_en ? f_ovr : vals[{b0.s1, b0.s0}];

  mux_scan_sampler #(.SETTLE(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  mux_scan_sampler #(.SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

  logic [1:0] o_sel;
  logic       o_busy, o_fv;
  logic [3:0] o_frame;
  assign o_sel   = use0 ? {b0.s1, b0.s0} : {b2.s1, b2.s0};
  assign o_busy  = use0 ? b0.busy        : b2.busy;
  assign o_fv    = use0 ? b0.frame_valid : b2.frame_valid;
  assign o_frame = use0 ? b0.frame       : b2.frame;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"},   32'(o_sel),   0);
    chk({tag, "_busy"},  32'(o_busy),  0);
    chk({tag, "_fv"},    32'(o_fv),    0);
    chk({tag, "_frame"}, 32'(o_frame), 0);
  endtask

  // exp_lat counts edges after the accepting edge until frame_valid is seen
  task automatic do_scan(input logic [3:0] m, input logic [3:0] exp_frame,
                         input int exp_lat, input int settle, input logic hold_start);
    logic [1:0] seq[$];
    int n;
    seq = {};
    for (int c = 0; c < 4; c++)
      if (m[c]) for (int d = 0; d <= settle; d++) seq.push_back(2'(c));
    start = 1'b1; frame_ready = 1'b1; mask = m;
    step;
    start = hold_start; frame_ready = 1'b0; mask = ~m;
    n = 0;
    while (o_fv !== 1'b1 && n < 40) begin
      chk("scan_busy", 32'(o_busy), 1);
      chk("scan_sel", 32'(o_sel), (n < seq.size()) ? 32'(seq[n]) : 32'hdead);
      step;
      n++;
    end
    chk("latency",  n, exp_lat);
    chk("valid_fv", 32'(o_fv), 1);
    chk("valid_busy", 32'(o_busy), 0);
    chk("valid_sel", 32'(o_sel), 0);
    chk("frame", 32'(o_frame), 32'(exp_frame));
    start = 1'b0;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; frame_ready = 1'b0; mask = 4'd0;
    vals = 4'd0; f_ovr_en = 1'b0; f_ovr = 1'b0; use0 = 1'b0;
    #1;
    chk_zero("rst2");
    use0 = 1'b1; #1;
    chk_zero("rst0");
    use0 = 1'b0;
    #10 rst = 1'b0;

    // a,b,c,d = 1,0,1,1 ; first edge after reset release accepts
    vals = 4'b1101;
    do_scan(4'b1111, 4'b1101, 12, 2, 1'b0);

    frame_ready = 1'b1;
    step;
    frame_ready = 1'b0;
    chk("idle_fv", 32'(o_fv), 0);
    chk("idle_frame", 32'(o_frame), 32'h0000000d);

    // disabled channels read 0 even though their inputs are 1
    vals = 4'b1111;
    do_scan(4'b1010, 4'b1010, 6, 2, 1'b0);

    // stalled consumer: start and f wiggle but nothing moves
    f_ovr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start = i[0]; f_ovr = ~f_ovr;
      step;
      chk("hold_fv", 32'(o_fv), 1);
      chk("hold_frame", 32'(o_frame), 32'h0000000a);
      chk("hold_busy", 32'(o_busy), 0);
    end
    f_ovr_en = 1'b0;
    vals = 4'b0101;
    do_scan(4'b1111, 4'b0101, 12, 2, 1'b0);
    do_scan(4'b0000, 4'b0000, 0, 2, 1'b0);
    frame_ready = 1'b1;
    step;
    frame_ready = 1'b0;

    // reset during channel 2 dwell
    vals = 4'b1111; start = 1'b1; mask = 4'b1111;
    step;
    start = 1'b0;
    for (int i = 0; i < 6; i++) step;
    chk("pre_rst_sel", 32'(o_sel), 2);
    chk("pre_rst_frame", 32'(o_frame), 32'h00000003);
    #2 rst = 1'b1;
    #1;
    chk_zero("async_rst");
    step;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (o_fv || o_busy) seen = 1'b1;
    end
    chk("no_fv_after_rst", 32'(seen), 0);

    // SETTLE=0 with start held high through the scan
    use0 = 1'b1; #1;
    chk_zero("idle0");
    vals = 4'b0110;
    do_scan(4'b1111, 4'b0110, 4, 0, 1'b1);
    frame_ready = 1'b1;
    step;
    frame_ready = 1'b0;
    chk("idle0_fv", 32'(o_fv), 0);
    chk("idle0_busy", 32'(o_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
